sha256_mem_responder: RTL and testbench

Word-addressed memory responder that serves the memory-master port of the SHA-256 engine: it answers engine reads with registered data, accepts the engine's eight hash write-backs, and captures them into a 256-bit digest register with completion and error status. A separate host port preloads message words and reads memory back. It sits between the engine's memory interface and the testbench or system host.

---
 rtl/sha256_mem_responder.sv | 149 ++++++++++++++
 tb/tb_sha256_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_mem_responder.sv
// sha256_mem_responder: word memory behind the SHA-256 engine master port.
// Serves engine reads, takes host preloads and captures the 8-word digest.
module sha256_mem_responder #(
   parameter int DEPTH = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         mem_we,
   input  logic [15:0]  mem_addr,
   input  logic [31:0]  mem_write_data,
   output logic [31:0]  mem_read_data,
   input  logic         host_en,
   input  logic         host_we,
   input  logic [15:0]  host_addr,
   input  logic [31:0]  host_wdata,
   output logic [31:0]  host_rdata,
   input  logic         arm,
   input  logic [15:0]  out_base,
   output logic [255:0] digest,
   output logic [7:0]   digest_mask,
   output logic         digest_done,
   output logic         range_err,
   output logic         dup_err,
   output logic         conflict
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0] LIMIT = 17'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURE,
      DONE
   } state_t;

   state_t      state;
   logic [15:0] base;
   logic [31:0] mem [DEPTH];

   logic        host_wr_req;
   logic        host_wr;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ok;
   logic        eng_rd_ok;
   logic        host_rd_ok;
   logic [15:0] offset;
   logic [2:0]  word;
   logic        hit;
   logic        cap;
   logic [7:0]  new_mask;

   // Single write port: the engine always wins over the host.
   always_comb begin
      host_wr_req = host_en & host_we;
      host_wr     = host_wr_req & ~mem_we;
      wr_en       = mem_we | host_wr;
      wr_addr     = mem_we ? mem_addr : host_addr;
      wr_data     = mem_we ? mem_write_data : host_wdata;
      wr_ok       = {1'b0, wr_addr} < LIMIT;
      eng_rd_ok   = {1'b0, mem_addr} < LIMIT;
      host_rd_ok  = {1'b0, host_addr} < LIMIT;
   end

   // Window hit decode; the 16-bit subtraction gives the wrap for free.
   always_comb begin
      offset   = mem_addr - base;
      word     = offset[2:0];
      hit      = mem_we && (offset[15:3] == 13'd0);
      cap      = hit && (state != IDLE) && !arm;
      new_mask = digest_mask | (8'b1 << word);
   end

   // Storage array, no reset on contents.
   always_ff @(posedge clk) begin
      if (wr_en && wr_ok)
         mem[wr_addr[AW-1:0]] <= wr_data;
   end

   // Engine read port, read-first, refreshed every cycle.
   always_ff @(posedge clk) begin
      if (reset)
         mem_read_data <= '0;
      else if (eng_rd_ok)
         mem_read_data <= mem[mem_addr[AW-1:0]];
      else
         mem_read_data <= '0;
   end

   // Host read port, read-first, holds when host_en is low.
   always_ff @(posedge clk) begin
      if (reset)
         host_rdata <= '0;
      else if (host_en) begin
         if (host_rd_ok)
            host_rdata <= mem[host_addr[AW-1:0]];
         else
            host_rdata <= '0;
      end
   end

   // Capture FSM with digest, mask and sticky status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         base        <= '0;
         digest      <= '0;
         digest_mask <= '0;
         digest_done <= 1'b0;
         range_err   <= 1'b0;
         dup_err     <= 1'b0;
         conflict    <= 1'b0;
      end else if (arm) begin
         state       <= ARMED;
         base        <= out_base;
         digest      <= '0;
         digest_mask <= '0;
         digest_done <= 1'b0;
         range_err   <= 1'b0;
         dup_err     <= 1'b0;
         conflict    <= 1'b0;
      end else begin
         if (wr_en && !wr_ok)
            range_err <= 1'b1;
         if (mem_we && host_wr_req)
            conflict <= 1'b1;
         if (cap) begin
            digest[{~word, 5'd0} +: 32] <= mem_write_data;
            digest_mask <= new_mask;
            if (digest_mask[word])
               dup_err <= 1'b1;
            unique case (state)
               ARMED, CAPTURE: begin
                  if (new_mask == 8'hFF) begin
                     state       <= DONE;
                     digest_done <= 1'b1;
                  end else begin
                     state <= CAPTURE;
                  end
               end
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sha256_mem_responder.sv
// tb_sha256_mem_responder: directed plan plus random traffic
// checked against a behavioural memory/digest model.
module tb_sha256_mem_responder;

   localparam int DEPTH = 1024;

   logic         clk = 1'b0;
   logic         reset;
   logic         mem_we;
   logic [15:0]  mem_addr;
   logic [31:0]  mem_write_data;
   logic [31:0]  mem_read_data;
   logic         host_en;
   logic         host_we;
   logic [15:0]  host_addr;
   logic [31:0]  host_wdata;
   logic [31:0]  host_rdata;
   logic         arm;
   logic [15:0]  out_base;
   logic [255:0] digest;
   logic [7:0]   digest_mask;
   logic         digest_done;
   logic         range_err;
   logic         dup_err;
   logic         conflict;

   sha256_mem_responder #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data),
      .host_en(host_en),
      .host_we(host_we),
      .host_addr(host_addr),
      .host_wdata(host_wdata),
      .host_rdata(host_rdata),
      .arm(arm),
      .out_base(out_base),
      .digest(digest),
      .digest_mask(digest_mask),
      .digest_done(digest_done),
      .range_err(range_err),
      .dup_err(dup_err),
      .conflict(conflict)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_mem [DEPTH];
   bit          m_known [DEPTH];
   logic [15:0] m_base;
   bit          m_cap;
   logic [7:0]  m_mask;
   logic [31:0] m_dw [8];
   bit          m_dup, m_rng, m_cnf;
   logic [31:0] e_rd, e_hrd;
   bit          e_rd_v, e_hrd_v;

   logic [31:0] hconst [8] = '{32'h6a09e667, 32'hbb67ae85,
      32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c,
      32'h1f83d9ab, 32'h5be0cd19};

   task automatic check(input string tag, input logic [255:0] obs,
                        input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      mem_we = 0; mem_addr = 0; mem_write_data = 0;
      host_en = 0; host_we = 0; host_addr = 0; host_wdata = 0;
      arm = 0; out_base = 0;
   endtask

   function automatic logic [255:0] exp_digest();
      logic [255:0] d;
      for (int k = 0; k < 8; k++)
         d[255-32*k -: 32] = m_dw[k];
      return d;
   endfunction

   function automatic void clear_capture();
      m_mask = 0;
      for (int k = 0; k < 8; k++) m_dw[k] = 0;
      m_dup = 0; m_rng = 0; m_cnf = 0;
   endfunction

   // Apply one clock of stimulus to the model, then compare.
   task automatic step();
      int off;
      int k;
      bit hw;
      bit rset;
      if (reset) begin
         e_rd = 0; e_rd_v = 1; e_hrd = 0; e_hrd_v = 1;
         m_cap = 0; m_base = 0;
         clear_capture();
      end else begin
         if (int'(mem_addr) >= DEPTH) begin
            e_rd = 0; e_rd_v = 1;
         end else begin
            e_rd = m_mem[mem_addr[9:0]];
            e_rd_v = m_known[mem_addr[9:0]];
         end
         if (host_en) begin
            if (int'(host_addr) >= DEPTH) begin
               e_hrd = 0; e_hrd_v = 1;
            end else begin
               e_hrd = m_mem[host_addr[9:0]];
               e_hrd_v = m_known[host_addr[9:0]];
            end
         end
         hw = host_en && host_we && !mem_we;
         rset = 0;
         if (mem_we) begin
            if (int'(mem_addr) < DEPTH) begin
               m_mem[mem_addr[9:0]] = mem_write_data;
               m_known[mem_addr[9:0]] = 1;
            end else rset = 1;
         end else if (hw) begin
            if (int'(host_addr) < DEPTH) begin
               m_mem[host_addr[9:0]] = host_wdata;
               m_known[host_addr[9:0]] = 1;
            end else rset = 1;
         end
         off = (int'(mem_addr) - int'(m_base) + 65536) % 65536;
         if (arm) begin
            m_base = out_base;
            m_cap = 1;
            clear_capture();
         end else begin
            if (rset) m_rng = 1;
            if (mem_we && host_en && host_we) m_cnf = 1;
            if (m_cap && mem_we && off < 8) begin
               k = off;
               if (m_mask[k]) m_dup = 1;
               m_mask[k] = 1;
               m_dw[k] = mem_write_data;
            end
         end
      end
      @(posedge clk);
      #1;
      if (e_rd_v) check("mem_read_data", mem_read_data, e_rd);
      if (e_hrd_v) check("host_rdata", host_rdata, e_hrd);
      check("digest", digest, exp_digest());
      check("digest_mask", digest_mask, m_mask);
      check("digest_done", digest_done, m_cap && m_mask == 8'hFF);
      check("range_err", range_err, m_rng);
      check("dup_err", dup_err, m_dup);
      check("conflict", conflict, m_cnf);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         m_known[i] = 0; m_mem[i] = 0;
      end
      m_base = 0; m_cap = 0;
      clear_capture();
      e_rd_v = 0; e_hrd_v = 0; e_rd = 0; e_hrd = 0;
      clr();
      reset = 1;
      step();
      step();
      check("rst_rd", mem_read_data, 32'h0);
      check("rst_hrd", host_rdata, 32'h0);
      check("rst_mask", digest_mask, 8'h0);
      reset = 0;

      // host preload
      for (int i = 0; i < 20; i++) begin
         clr(); host_en = 1; host_we = 1;
         host_addr = 16'(i); host_wdata = 32'(i + 1);
         step();
      end
      clr(); mem_addr = 16'd5; step();
      check("rd5", mem_read_data, 32'h6);
      clr(); mem_addr = 16'd2000; step();
      check("rd2000", mem_read_data, 32'h0);

      // full digest capture
      clr(); arm = 1; out_base = 16'h0100; step();
      for (int i = 0; i < 8; i++) begin
         clr(); mem_we = 1; mem_addr = 16'h0100 + 16'(i);
         mem_write_data = hconst[i];
         step();
         if (i == 6) check("done_early", digest_done, 1'b0);
      end
      check("done", digest_done, 1'b1);
      check("h0", digest[255:224], 32'h6a09e667);
      check("h7", digest[31:0], 32'h5be0cd19);

      // wrapped window
      clr(); arm = 1; out_base = 16'hFFFC; step();
      for (int i = 0; i < 8; i++) begin
         clr(); mem_we = 1; mem_addr = 16'hFFFC + 16'(i);
         mem_write_data = 32'hC0DE0000 + 32'(i);
         step();
         if (i == 0) check("rng_first", range_err, 1'b1);
      end
      check("wrap_mask", digest_mask, 8'hFF);
      check("wrap_done", digest_done, 1'b1);
      check("wrap_h4", digest[127:96], 32'hC0DE0004);

      // write arbitration
      clr(); host_en = 1; host_we = 1; host_addr = 16'd10;
      host_wdata = 32'hDEAD; mem_we = 1; mem_addr = 16'd11;
      mem_write_data = 32'hBEEF; step();
      check("conflict", conflict, 1'b1);
      clr(); host_en = 1; host_addr = 16'd10; mem_addr = 16'd11; step();
      check("addr10", host_rdata, 32'hB);
      check("addr11", mem_read_data, 32'hBEEF);
      clr(); arm = 1; out_base = 16'h0040; step();
      check("cnf_clr", conflict, 1'b0);

      // duplicate write, then arm racing a window write
      clr(); mem_we = 1; mem_addr = 16'h0043; mem_write_data = 32'hA; step();
      clr(); mem_we = 1; mem_addr = 16'h0043; mem_write_data = 32'hB; step();
      check("dup", dup_err, 1'b1);
      check("w3", digest[159:128], 32'hB);
      clr(); arm = 1; out_base = 16'h0040; mem_we = 1;
      mem_addr = 16'h0040; mem_write_data = 32'h77; step();
      check("arm_mask", digest_mask, 8'h0);
      clr(); mem_addr = 16'h0040; step();
      check("arm_arr", mem_read_data, 32'h77);

      // reset mid-capture
      clr(); arm = 1; out_base = 16'h0080; step();
      for (int i = 0; i < 4; i++) begin
         clr(); mem_we = 1; mem_addr = 16'h0080 + 16'(i);
         mem_write_data = 32'h1000 + 32'(i);
         step();
      end
      check("part_mask", digest_mask, 8'h0F);
      clr(); reset = 1; step(); reset = 0;
      check("rst_mask2", digest_mask, 8'h0);
      clr(); mem_we = 1; mem_addr = 16'd2; mem_write_data = 32'h55; step();
      check("idle_nocap", digest_mask, 8'h0);
      for (int i = 4; i < 10; i++) begin
         clr(); host_en = 1; host_addr = 16'(i); step();
         check("keep", host_rdata, 32'(i + 1));
      end

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         clr();
         reset = ($urandom_range(0, 299) == 0);
         if (!reset) begin
            if ($urandom_range(0, 19) == 0) begin
               arm = 1;
               case ($urandom_range(0, 2))
                  0: out_base = 16'($urandom_range(0, 40));
                  1: out_base = 16'hFFFC + 16'($urandom_range(0, 3));
                  default: out_base = 16'($urandom);
               endcase
            end
            mem_we = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
               0, 1: mem_addr = m_base + 16'($urandom_range(0, 9));
               2: mem_addr = 16'($urandom_range(0, 63));
               default: mem_addr = 16'($urandom);
            endcase
            mem_write_data = $urandom;
            host_en = $urandom_range(0, 1) == 1;
            host_we = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0)
               host_addr = 16'($urandom);
            else
               host_addr = 16'($urandom_range(0, 63));
            host_wdata = $urandom;
         end
         step();
      end
      reset = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
